// File: rtl/wide_add_pkg.sv
// Shared types and constants for the sequential wide adder.
package wide_add_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_16bit.sv
// 16-bit ripple adder slice with carry in and carry out.
module full_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};

endmodule

// File: rtl/wide_add_seq.sv
// Wide add/subtract built by time-sharing one 16-bit adder over WORDS slices,
// least-significant slice first, with the carry held in a register between cycles.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SLICE_W*WORDS-1:0] op_a,
  input  logic [SLICE_W*WORDS-1:0] op_b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SLICE_W*WORDS-1:0] result,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int W  = SLICE_W * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BW = $clog2(W);

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_lat;
  logic [W-1:0]    b_lat;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_next;
  logic [BW-1:0]   base;
  logic            last;
  logic [15:0]     fa_a;
  logic [15:0]     fa_b;
  logic [15:0]     fa_sum;
  logic            fa_cout;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Bit offset of the current slice: idx * 16.
  assign base = BW'({idx, 4'b0000});
  assign last = (idx == IW'(WORDS - 1));
  assign fa_a = a_lat[base +: SLICE_W];
  assign fa_b = b_lat[base +: SLICE_W];

  full_adder_16bit u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Partial sums build up in acc so result stays frozen until the last slice.
  always_comb begin
    acc_next = acc;
    acc_next[base +: SLICE_W] = fa_sum;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_lat <= op_a;
      b_lat <= op_b ^ {W{sub}};
    end
    if (state == RUN) begin
      acc <= acc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= RUN;
            carry <= sub;
            idx   <= '0;
          end
        end
        RUN: begin
          carry <= fa_cout;
          if (last) begin
            state  <= DONE;
            idx    <= '0;
            result <= acc_next;
            cout   <= fa_cout;
            // Signed overflow: operands agree in sign but the sum does not.
            ovf    <= (fa_a[15] == fa_b[15]) && (fa_sum[15] != fa_a[15]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Randomized and directed bench for wide_add_seq at WORDS=4 and WORDS=1.
module tb_wide_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, busy;
  logic [63:0] op_a, op_b, result;
  logic        in_valid1, in_ready1, sub1, out_valid1, out_ready1, cout1, ovf1, busy1;
  logic [15:0] op_a1, op_b1, result1;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  wide_add_seq #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .cout(cout), .ovf(ovf), .busy(busy)
  );

  wide_add_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .sub(sub1), .out_valid(out_valid1),
    .out_ready(out_ready1), .result(result1), .cout(cout1), .ovf(ovf1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // Reference: plain unsigned/signed arithmetic on n-bit operands.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic s, input int n,
                       output logic [63:0] r, output logic c, output logic v);
    logic [64:0] full;
    logic [63:0] mask;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    if (s) begin
      r = (a - b) & mask;
      c = (a >= b);
      v = (a[n-1] != b[n-1]) && (r[n-1] != a[n-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b};
      r = full[63:0] & mask;
      c = full[n];
      v = (a[n-1] == b[n-1]) && (r[n-1] != a[n-1]);
    end
  endtask

  task automatic wait_out4(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run4(input string tag, input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [63:0] er;
    logic ec, ev;
    int lat;
    model(a, b, s, 64, er, ec, ev);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; sub = ~s;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    wait_out4(lat);
    check({tag, ".lat"}, 64'(lat), 64'd4);
    check({tag, ".result"}, result, er);
    check({tag, ".cout"}, 64'(cout), 64'(ec));
    check({tag, ".ovf"}, 64'(ovf), 64'(ev));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".idle"}, 64'({in_ready, out_valid}), 64'b10);
    check({tag, ".held"}, result, er);
  endtask

  task automatic run1(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [63:0] er;
    logic ec, ev;
    int lat;
    model(64'(a), 64'(b), s, 16, er, ec, ev);
    op_a1 = a; op_b1 = b; sub1 = s; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    op_a1 = 16'($urandom);
    lat = 0;
    while (!out_valid1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'd1);
    check({tag, ".result"}, 64'(result1), er);
    check({tag, ".cout"}, 64'(cout1), 64'(ec));
    check({tag, ".ovf"}, 64'(ovf1), 64'(ev));
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check({tag, ".idle"}, 64'(in_ready1), 64'd1);
  endtask

  initial begin
    logic [63:0] e1, e2, pick[4];
    logic c1, v1;
    int lat;
    bit seen;
    rst = 1'b1;
    in_valid = 0; op_a = 0; op_b = 0; sub = 0; out_ready = 0;
    in_valid1 = 0; op_a1 = 0; op_b1 = 0; sub1 = 0; out_ready1 = 0;
    @(posedge clk); @(posedge clk); #1;
    check("rst.ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
    check("rst.data", result, 64'd0);
    check("rst.flags", 64'({cout, ovf}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run4("carry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
    run4("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    run4("borrow", 64'h0000_0000_0001_0000, 64'd1, 1'b1);
    run4("under", 64'd0, 64'd1, 1'b1);
    run4("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    run4("sovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1);

    pick[0] = 64'd0; pick[1] = '1; pick[2] = 64'h7FFF_FFFF_FFFF_FFFF; pick[3] = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 12; i++) begin
      logic [63:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : {$urandom, $urandom};
      run4($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)));
    end

    // Backpressure: result holds, second request waits for a real IDLE cycle.
    model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64, e1, c1, v1);
    model(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b1, 64, e2, c1, v1);
    op_a = 64'h1234_5678_9ABC_DEF0; op_b = 64'h0FED_CBA9_8765_4321; sub = 0; in_valid = 1;
    @(posedge clk); #1;
    op_a = 64'd5; op_b = 64'd7; sub = 1;
    wait_out4(lat);
    check("bp.lat", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.hold", 64'({out_valid, in_ready}), 64'b10);
      check("bp.result", result, e1);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("bp.release", 64'({busy, in_ready}), 64'b01);
    check("bp.kept", result, e1);
    @(posedge clk); #1;
    in_valid = 0;
    check("bp.accept2", 64'(busy), 64'd1);
    wait_out4(lat);
    check("bp.lat2", 64'(lat), 64'd4);
    check("bp.result2", result, e2);
    check("bp.cout2", 64'(cout), 64'(c1));
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;

    // Reset during slice 2 aborts the operation.
    op_a = '1; op_b = 64'd1; sub = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    #1;
    check("abort.ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
    check("abort.result", result, 64'd0);
    @(posedge clk); #1;
    rst = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("abort.no_valid", 64'(seen), 64'd0);

    run1("w1.basic", 16'hABCD, 16'h1234, 1'b0);
    run1("w1.sub", 16'h0000, 16'h0001, 1'b1);
    run1("w1.ovf", 16'h7FFF, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++)
      run1($sformatf("w1.rnd%0d", i), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
